tinker_regfile_sb: RTL and testbench
====================================

// Module: tinker_regfile_sb
// PURPOSE
//  Parametrised multi-read-port register file with write-through bypass and an integrated
//  per-register pending-write scoreboard for the pipelined tinker_core.
//  Sits in ID: sources are read and checked for RAW hazards; the issue port reserves the
//  destination; the WB write port retires the reservation.
//  Replaces the single-ported, hazard-blind file; the pipeline uses issue_ready as its ID stall.
// PARAMETERS
//  XLEN      64        data width
//  NREGS     32        architectural registers; must be a power of two
//  NREAD     3         read ports (rs, rt, rd-as-source)
//  PEND_W    2         pending counter width; max in-flight writes per reg = 2**PEND_W-1
//  SP_INDEX  31        stack-pointer register index
//  SP_RESET  'h80000   reset value of register SP_INDEX
// PORTS
//  clk            in   1              clock, rising edge
//  reset          in   1              asynchronous reset, active-high
//  rd_en          in   NREAD          port i is a real source of the issuing instruction
//  rd_addr        in   NREAD*AW       flat source indices, AW=$clog2(NREGS); port i at [i*AW+:AW]
//  rd_data        out  NREAD*XLEN     flat read data; port i at [i*XLEN+:XLEN]
//  sp_val         out  XLEN           current value of register SP_INDEX (bypassed)
//  issue_valid    in   1              ID holds an instruction that wants to issue
//  issue_we       in   1              the instruction writes a register
//  issue_dst      in   AW             destination index
//  issue_ready    out  1              no hazard; issue_fire = issue_valid & issue_ready
//  wr_en          in   1              WB write / retire
//  wr_addr        in   AW             WB destination index
//  wr_data        in   XLEN           WB data
//  busy_mask      out  NREGS          bit r = (pend[r] != 0)
//  err_underflow  out  1              sticky: retire arrived for a register with pend == 0
// BEHAVIOUR
//  - Reset (async, immediate): regs 0, except reg SP_INDEX = SP_RESET; all pend[] = 0;
//    err_underflow = 0. Outputs at reset: busy_mask = 0, issue_ready = 1, sp_val = SP_RESET.
//  - Read: combinational, 0-cycle latency. If wr_en & wr_addr == rd_addr[i],
//    rd_data[i] = wr_data (write-through); otherwise regs[rd_addr[i]]. sp_val is bypassed the same way.
//  - Write: at posedge clk, if wr_en then regs[wr_addr] <= wr_data.
//    Every register, including index 0, is writable.
//  - Scoreboard update for each register r, applied at posedge clk:
//      inc = issue_fire & issue_we & (issue_dst == r)
//      dec = wr_en & (wr_addr == r)
//      inc & dec           -> pend unchanged
//      inc only            -> pend + 1
//      dec only, pend > 0  -> pend - 1
//      dec only, pend == 0 -> pend stays 0, err_underflow <= 1 (cleared only by reset)
//  - Hazard (combinational) is the OR of two terms:
//      src_hz(i) = rd_en[i] & pend[rd_addr[i]] != 0 & !(dec on rd_addr[i] & pend[rd_addr[i]] == 1)
//        i.e. a retire of the last outstanding write clears the hazard in the same cycle via bypass.
//      dst_hz = issue_we & pend[issue_dst] == 2**PEND_W-1, unless a dec on issue_dst occurs this cycle.
//    issue_ready = !(OR_i src_hz(i) | dst_hz).
//    issue_ready is independent of issue_valid; there is no combinational path from issue_valid.
//  - Issuing from a stalled ID: issue_fire is 0, so the scoreboard is untouched; ID holds its inputs.
//  - Duplicate sources (same addr on several ports) and src == dst are legal; the hazard is
//    evaluated against pre-edge pend.
//  - Flush: no flush port. The pipeline must retire every fired issue_we with a wr_en to the same
//    register; squashed instructions retire with wr_en = 1 and their own wr_data being
//    discarded upstream (WB writes back the old value) or are not fired.
//  - Reset mid-operation: all pending reservations are dropped, no error is flagged;
//    stale WB writes after reset are the pipeline's responsibility.
// STRUCTURE
//  - tinker_pkg holds: XLEN, NREGS, REG_AW, SP_INDEX, SP_RESET, and the opcode enum shared with the decoder.
//  - Sub-module tinker_sb_counter: one PEND_W-bit saturating up/down counter with inc, dec, cnt,
//    is_max, underflow. Instantiated NREGS times in a generate loop. Storage and bypass muxes
//    live inline in the top.
// TESTING
//  1 Reset: assert reset mid-clock -> regs read 0, sp_val = 'h80000, busy_mask = 0,
//    issue_ready = 1 without waiting for a clock edge.
//  2 Bypass: wr_en=1, wr_addr=5, wr_data='hDEAD, rd_addr[0]=5 -> rd_data[0]='hDEAD that cycle;
//    next cycle, with wr_en=0, still 'hDEAD.
//  3 RAW stall: fire issue_we dst=7 -> busy_mask[7]=1; next cycle rd_en[1]=1, rd_addr[1]=7
//    -> issue_ready=0; when wr_en on r7 arrives with wr_data=42, issue_ready=1 and rd_data[1]=42
//    in the same cycle.
//  4 Saturation (PEND_W=2): fire 3 writes to r3 -> 4th issue_we dst=3 sees issue_ready=0;
//    one retire on r3 in the same cycle -> issue_ready=1 and pend stays 3.
//  5 Simultaneous issue and retire on r9 with pend=1 -> pend stays 1, busy_mask[9]=1, no error.
//  6 Underflow: wr_en on r12 with pend=0 -> err_underflow=1 next cycle and stays 1 until reset;
//    pend[12]=0.

Source files
------------

// File: rtl/tinker_pkg.sv
// Shared tinker_core constants and the decoder opcode set.
// Sizing here is the default configuration of the register file and scoreboard.
package tinker_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned REG_AW   = $clog2(NREGS);
  localparam int unsigned PEND_W   = 2;
  localparam int unsigned SP_INDEX = 31;
  localparam logic [XLEN-1:0] SP_RESET = 64'h8_0000;

  typedef enum logic [4:0] {
    OpAnd    = 5'h00,
    OpOr     = 5'h01,
    OpXor    = 5'h02,
    OpNot    = 5'h03,
    OpShftr  = 5'h04,
    OpShftri = 5'h05,
    OpShftl  = 5'h06,
    OpShftli = 5'h07,
    OpBr     = 5'h08,
    OpBrr    = 5'h09,
    OpBrri   = 5'h0a,
    OpBrnz   = 5'h0b,
    OpCall   = 5'h0c,
    OpReturn = 5'h0d,
    OpBrgt   = 5'h0e,
    OpPriv   = 5'h0f,
    OpMovLd  = 5'h10,
    OpMovRr  = 5'h11,
    OpMovL   = 5'h12,
    OpMovSt  = 5'h13,
    OpAddf   = 5'h14,
    OpSubf   = 5'h15,
    OpMulf   = 5'h16,
    OpDivf   = 5'h17,
    OpAdd    = 5'h18,
    OpAddi   = 5'h19,
    OpSub    = 5'h1a,
    OpSubi   = 5'h1b,
    OpMul    = 5'h1c,
    OpDiv    = 5'h1d
  } opcode_e;

endpackage

// File: rtl/tinker_sb_counter.sv
// Per-register pending-write counter: saturating up/down, with an underflow strobe
// when a retire arrives while nothing is outstanding.
module tinker_sb_counter #(
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              is_max,
  output logic              underflow
);

  localparam logic [PEND_W-1:0] CntMax = '1;

  logic [PEND_W-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel; an inc at max is held off by the issue hazard.
  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (cnt_q != CntMax) cnt_d = cnt_q + PEND_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) underflow = 1'b1;
      else             cnt_d     = cnt_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign is_max = (cnt_q == CntMax);

endmodule

// File: rtl/tinker_regfile_sb.sv
// Multi-read-port register file with write-through bypass and a per-register
// pending-write scoreboard that produces the ID-stage issue stall.
module tinker_regfile_sb #(
  parameter int unsigned      XLEN     = tinker_pkg::XLEN,
  parameter int unsigned      NREGS    = tinker_pkg::NREGS,
  parameter int unsigned      NREAD    = 3,
  parameter int unsigned      PEND_W   = tinker_pkg::PEND_W,
  parameter int unsigned      SP_INDEX = tinker_pkg::SP_INDEX,
  parameter logic [XLEN-1:0]  SP_RESET = XLEN'(tinker_pkg::SP_RESET),
  localparam int unsigned     AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [XLEN-1:0]       sp_val,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [AW-1:0]         issue_dst,
  output logic                  issue_ready,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic [NREGS-1:0]      busy_mask,
  output logic                  err_underflow
);

  import tinker_pkg::*;

  localparam logic [AW-1:0] SpAddr = AW'(SP_INDEX);

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [PEND_W-1:0] pend   [NREGS];
  logic [NREGS-1:0]  inc, dec, is_max, uflow;
  logic [NREAD-1:0]  src_hz;
  logic              dst_hz;
  logic              issue_fire;
  logic              err_q;

  // Storage: every index is writable, including 0; SP gets its own reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= (r == SP_INDEX) ? SP_RESET : '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_sb
    assign inc[r]       = issue_fire & issue_we & (issue_dst == AW'(r));
    assign dec[r]       = wr_en & (wr_addr == AW'(r));
    assign busy_mask[r] = |pend[r];

    tinker_sb_counter #(
      .PEND_W (PEND_W)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc[r]),
      .dec       (dec[r]),
      .cnt       (pend[r]),
      .is_max    (is_max[r]),
      .underflow (uflow[r])
    );
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[i*AW +: AW];
    assign rd_data[i*XLEN +: XLEN] = (wr_en && (wr_addr == addr)) ? wr_data : regs_q[addr];
    // Retiring the last outstanding write forwards through the bypass, so no stall.
    assign src_hz[i] = rd_en[i] & busy_mask[addr] &
                       ~(dec[addr] & (pend[addr] == PEND_W'(1)));
  end

  assign sp_val = (wr_en && (wr_addr == SpAddr)) ? wr_data : regs_q[SpAddr];

  assign dst_hz      = issue_we & is_max[issue_dst] & ~dec[issue_dst];
  assign issue_ready = ~((|src_hz) | dst_hz);
  assign issue_fire  = issue_valid & issue_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       err_q <= 1'b0;
    else if (|uflow) err_q <= 1'b1;
  end

  assign err_underflow = err_q;

endmodule

// File: tb/tb_tinker_regfile_sb.sv
// Bench for tinker_regfile_sb: directed sequences, a cycle table, and random
// traffic against a behavioural register/scoreboard model.
module tb_tinker_regfile_sb;

  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam logic [63:0] SpRst = 64'h8_0000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   rd_en = '0;
  logic [14:0]  rd_addr = '0;
  logic [191:0] rd_data;
  logic [63:0]  sp_val;
  logic         issue_valid = 1'b0;
  logic         issue_we = 1'b0;
  logic [4:0]   issue_dst = '0;
  logic         issue_ready;
  logic         wr_en = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [63:0]  wr_data = '0;
  logic [31:0]  busy_mask;
  logic         err_underflow;

  int total = 0;
  int bad = 0;

  tinker_regfile_sb dut (
    .clk           (clk),
    .reset         (reset),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .sp_val        (sp_val),
    .issue_valid   (issue_valid),
    .issue_we      (issue_we),
    .issue_dst     (issue_dst),
    .issue_ready   (issue_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy_mask     (busy_mask),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Behavioural model: architectural state plus outstanding-write counts.
  logic [63:0] m_regs [NR];
  int          m_pend [NR];
  bit          m_err;

  task automatic m_reset();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = (r == 31) ? SpRst : 64'd0;
      m_pend[r] = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic bit m_ready();
    bit hz = 1'b0;
    for (int p = 0; p < 3; p++) begin
      int a = int'(rd_addr[p*AW +: AW]);
      bit last_retired = wr_en && (int'(wr_addr) == a) && (m_pend[a] == 1);
      if (rd_en[p] && m_pend[a] > 0 && !last_retired) hz = 1'b1;
    end
    if (issue_we && m_pend[issue_dst] == 3 && !(wr_en && wr_addr == issue_dst)) hz = 1'b1;
    return !hz;
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    return (wr_en && wr_addr == a) ? wr_data : m_regs[a];
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int r = 0; r < NR; r++) b[r] = (m_pend[r] != 0);
    return b;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic m_step();
    bit fire = issue_valid && m_ready();
    bit inc  = fire && issue_we;
    bit same = inc && wr_en && (wr_addr == issue_dst);
    if (wr_en) begin
      m_regs[wr_addr] = wr_data;
      if (!same) begin
        if (m_pend[wr_addr] == 0) m_err = 1'b1;
        else                      m_pend[wr_addr]--;
      end
    end
    if (inc && !same) m_pend[issue_dst]++;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  typedef struct {
    logic [2:0]  rden;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        wr;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        iv;
    logic        iwe;
    logic [4:0]  dst;
    logic [63:0] e_rd0;
    logic [63:0] e_rd1;
    logic        e_rdy;
    logic [31:0] e_busy;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] rden, input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic wr, input logic [4:0] wa, input logic [63:0] wd,
                              input logic iv, input logic iwe, input logic [4:0] dst,
                              input logic [63:0] e0, input logic [63:0] e1, input logic rdy,
                              input logic [31:0] busy);
    vec_t v;
    v.rden = rden; v.ra0 = ra0; v.ra1 = ra1; v.wr = wr; v.wa = wa; v.wd = wd;
    v.iv = iv; v.iwe = iwe; v.dst = dst;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_rdy = rdy; v.e_busy = busy;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    // Bypass, RAW stall, saturation and issue/retire-cancel, one row per cycle.
    tbl[0]  = mk(3'b000, 5, 7, 0, 0, 0,       1, 1, 5, 0,       0,  1, 0);
    tbl[1]  = mk(3'b000, 5, 7, 1, 5, 'hDEAD,  0, 0, 0, 'hDEAD,  0,  1, 32'h20);
    tbl[2]  = mk(3'b000, 5, 7, 0, 0, 0,       0, 0, 0, 'hDEAD,  0,  1, 0);
    tbl[3]  = mk(3'b000, 5, 7, 0, 0, 0,       1, 1, 7, 'hDEAD,  0,  1, 0);
    tbl[4]  = mk(3'b010, 5, 7, 0, 0, 0,       1, 0, 0, 'hDEAD,  0,  0, 32'h80);
    tbl[5]  = mk(3'b010, 5, 7, 1, 7, 42,      1, 0, 0, 'hDEAD,  42, 1, 32'h80);
    tbl[6]  = mk(3'b000, 5, 7, 0, 0, 0,       1, 1, 3, 'hDEAD,  42, 1, 0);
    tbl[7]  = mk(3'b000, 5, 7, 0, 0, 0,       1, 1, 3, 'hDEAD,  42, 1, 32'h8);
    tbl[8]  = mk(3'b000, 5, 7, 0, 0, 0,       1, 1, 3, 'hDEAD,  42, 1, 32'h8);
    tbl[9]  = mk(3'b000, 5, 7, 0, 0, 0,       1, 1, 3, 'hDEAD,  42, 0, 32'h8);
    tbl[10] = mk(3'b000, 5, 7, 1, 3, 7,       1, 1, 3, 'hDEAD,  42, 1, 32'h8);
    tbl[11] = mk(3'b000, 5, 7, 0, 0, 0,       1, 1, 3, 'hDEAD,  42, 0, 32'h8);
    tbl[12] = mk(3'b000, 5, 7, 1, 3, 'h11,    1, 1, 9, 'hDEAD,  42, 1, 32'h8);
    tbl[13] = mk(3'b000, 5, 7, 1, 3, 'h12,    0, 0, 0, 'hDEAD,  42, 1, 32'h208);
    tbl[14] = mk(3'b000, 5, 7, 1, 3, 'h13,    0, 0, 0, 'hDEAD,  42, 1, 32'h208);
    tbl[15] = mk(3'b001, 9, 7, 1, 9, 'h99,    1, 1, 9, 'h99,    42, 1, 32'h200);
    tbl[16] = mk(3'b000, 9, 7, 0, 0, 0,       0, 0, 0, 'h99,    42, 1, 32'h200);
    tbl[17] = mk(3'b000, 9, 7, 1, 9, 'h9A,    0, 0, 0, 'h9A,    42, 1, 32'h200);

    // Reset sequence: dirty some state, then reset mid-cycle and check immediately.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    issue_valid = 1; issue_we = 1; issue_dst = 7;
    @(posedge clk); #1;
    issue_valid = 0; issue_we = 0;
    wr_en = 1; wr_addr = 5; wr_data = 64'h55;
    @(posedge clk); #1;
    wr_addr = 31; wr_data = 64'h1234;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 3'b010; rd_addr = {5'd31, 5'd7, 5'd5};
    #1;
    chk("pre_rst_rd0", rd_data[63:0], 64'h55);
    chk("pre_rst_sp", sp_val, 64'h1234);
    chk("pre_rst_ready", 64'(issue_ready), 64'd0);
    chk("pre_rst_busy", 64'(busy_mask), 64'h80);
    chk("pre_rst_err", 64'(err_underflow), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_rd0", rd_data[63:0], 64'd0);
    chk("rst_rd2_sp", rd_data[191:128], SpRst);
    chk("rst_sp", sp_val, SpRst);
    chk("rst_busy", 64'(busy_mask), 64'd0);
    chk("rst_ready", 64'(issue_ready), 64'd1);
    chk("rst_err", 64'(err_underflow), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd_en = '0;

    for (int k = 0; k < 18; k++) begin
      rd_en = tbl[k].rden;
      rd_addr = {5'd0, tbl[k].ra1, tbl[k].ra0};
      wr_en = tbl[k].wr; wr_addr = tbl[k].wa; wr_data = tbl[k].wd;
      issue_valid = tbl[k].iv; issue_we = tbl[k].iwe; issue_dst = tbl[k].dst;
      #1;
      chk($sformatf("tbl%0d_rd0", k), rd_data[63:0], tbl[k].e_rd0);
      chk($sformatf("tbl%0d_rd1", k), rd_data[127:64], tbl[k].e_rd1);
      chk($sformatf("tbl%0d_ready", k), 64'(issue_ready), 64'(tbl[k].e_rdy));
      chk($sformatf("tbl%0d_busy", k), 64'(busy_mask), 64'(tbl[k].e_busy));
      chk($sformatf("tbl%0d_err", k), 64'(err_underflow), 64'd0);
      @(posedge clk); #1;
    end

    // Underflow: retire to an idle register sets the sticky error.
    rd_en = '0; issue_valid = 0; issue_we = 0;
    wr_en = 1; wr_addr = 12; wr_data = 64'h77;
    #1;
    chk("uf_pre_err", 64'(err_underflow), 64'd0);
    @(posedge clk); #1;
    wr_en = 0;
    #1;
    chk("uf_err", 64'(err_underflow), 64'd1);
    chk("uf_busy", 64'(busy_mask), 64'd0);
    issue_valid = 1; issue_we = 1; issue_dst = 12;
    @(posedge clk); #1;
    issue_valid = 0; issue_we = 0; wr_en = 1; wr_addr = 12;
    @(posedge clk); #1;
    wr_en = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("uf_sticky", 64'(err_underflow), 64'd1);
    chk("uf_busy_after", 64'(busy_mask), 64'd0);
    reset = 1'b1;
    #1;
    chk("uf_rst_clear", 64'(err_underflow), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Random traffic against the model.
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      int q[$];
      if (c % 700 == 699) begin
        reset = 1'b1;
        #1;
        chk("rand_rst_busy", 64'(busy_mask), 64'd0);
        chk("rand_rst_sp", sp_val, (wr_en && wr_addr == 5'd31) ? wr_data : SpRst);
        chk("rand_rst_err", 64'(err_underflow), 64'd0);
        m_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        continue;
      end
      rd_en = 3'($urandom);
      rd_addr = {rnd_addr(), rnd_addr(), rnd_addr()};
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_we = ($urandom_range(0, 3) != 0);
      issue_dst = rnd_addr();
      for (int r = 0; r < NR; r++) if (m_pend[r] > 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        wr_en = 1;
        wr_addr = (q.size() > 0 && $urandom_range(0, 19) != 0) ?
                  5'(q[$urandom_range(0, q.size() - 1)]) : rnd_addr();
      end else begin
        wr_en = ($urandom_range(0, 49) == 0);
        wr_addr = rnd_addr();
      end
      wr_data = {$urandom, $urandom};
      #1;
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("rand%0d_rd%0d", c, p), rd_data[p*64 +: 64], m_read(rd_addr[p*AW +: AW]));
      end
      chk($sformatf("rand%0d_sp", c), sp_val, m_read(5'd31));
      chk($sformatf("rand%0d_ready", c), 64'(issue_ready), 64'(m_ready()));
      chk($sformatf("rand%0d_busy", c), 64'(busy_mask), 64'(m_busy()));
      chk($sformatf("rand%0d_err", c), 64'(err_underflow), 64'(m_err));
      m_step();
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
